axi_reset_ctrl: RTL and testbench

Reset sequencer for the AXI BFM environment. It owns the active-high `reset` net of the AXI reset interface and shares it between several requesters through round-robin arbitration. For each granted request it waits for AXI quiescence, holds reset for a programmable number of cycles, then releases and settles before handshaking completion. It also performs a power-on reset sequence automatically after `reset_n` deasserts.

---
 rtl/axi_reset_ctrl_pkg.sv | 20 ++
 rtl/axi_reset_rr_arb.sv | 38 +++
 rtl/axi_reset_ctrl.sv | 138 +++++++++++++
 tb/tb_axi_reset_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/axi_reset_ctrl_pkg.sv
// Shared types and constants for the AXI reset sequencer.
package axi_reset_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_QUIESCE,
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } axi_rst_state_e;

  localparam int SETTLE_CYCLES = 4;

  // Requested hold length with a floor applied.
  function automatic int hold_floor(input int requested, input int floor_v);
    return (requested > floor_v) ? requested : floor_v;
  endfunction

endpackage

// File: rtl/axi_reset_rr_arb.sv
// Round-robin arbiter: one-hot winner from req, pointer moves past the winner on en.
module axi_reset_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   ptr
);

  logic [PTR_W-1:0] win_idx;
  logic             found;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        winner[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        win_idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_reset_ctrl.sv
// Reset sequencer sharing the AXI reset net between requesters, plus power-on reset.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_POR     | power-on hold of MIN_HOLD cycles after reset_n rises
// ST_IDLE    | waiting for a request; arbitrate and latch hold length
// ST_QUIESCE | waiting for axi_idle, bounded by QUIESCE_TIMEOUT
// ST_ASSERT  | axi_reset high for H cycles
// ST_RELEASE | axi_reset low, settle for SETTLE_CYCLES
// ST_DONE    | one-cycle done pulse to the owner
module axi_reset_ctrl
  import axi_reset_ctrl_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int HOLD_W          = 8,
  parameter int MIN_HOLD        = 16,
  parameter int QUIESCE_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [HOLD_W-1:0]  hold_cycles,
  input  logic               axi_idle,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               axi_reset,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TMO_W    = $clog2(QUIESCE_TIMEOUT + 1);
  localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [HOLD_W-1:0]   POR_TC    = HOLD_W'(MIN_HOLD - 1);
  localparam logic [TMO_W-1:0]    TMO_TC    = TMO_W'(QUIESCE_TIMEOUT);
  localparam logic [TMO_W-1:0]    TMO_PRE   = TMO_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

  axi_rst_state_e       state;
  logic                 from_por;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [NUM_REQ-1:0]   arb_winner;
  logic                 arb_en;

  assign arb_en = (state == ST_IDLE);

  axi_reset_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .en      (arb_en),
    .winner  (arb_winner),
    .ptr     ()
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_POR;
      from_por    <= 1'b1;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      settle_cnt  <= '0;
      grant       <= '0;
      done        <= '0;
      axi_reset   <= 1'b1;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        ST_POR: begin
          // hold_cnt counts up from its reset value here; ASSERT reuses it as a down-counter
          if (hold_cnt == POR_TC) begin
            state      <= ST_RELEASE;
            axi_reset  <= 1'b0;
            settle_cnt <= SETTLE_LD;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (|req) begin
            state    <= ST_QUIESCE;
            busy     <= 1'b1;
            grant    <= arb_winner;
            hold_cnt <= HOLD_W'(hold_floor(int'(hold_cycles), MIN_HOLD));
            tmo_cnt  <= '0;
          end
        end
        ST_QUIESCE: begin
          if (axi_idle || tmo_cnt == TMO_TC) begin
            state     <= ST_ASSERT;
            axi_reset <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_PRE) timeout_err <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            state      <= ST_RELEASE;
            axi_reset  <= 1'b0;
            settle_cnt <= SETTLE_LD;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (settle_cnt <= SETTLE_W'(1)) begin
            if (from_por) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              from_por <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= grant;
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_reset_ctrl.sv
// Directed bench for axi_reset_ctrl: POR, single request, hold floor, timeout, arbitration, mid-sequence reset.
module tb_axi_reset_ctrl;
  import axi_reset_ctrl_pkg::*;

  localparam int TB_MIN_HOLD = 16;
  localparam int TB_TMO      = 1024;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] hold_cycles;
  logic       axi_idle;
  logic [3:0] grant;
  logic [3:0] done;
  logic       axi_reset;
  logic       busy;
  logic       timeout_err;

  int vectors    = 0;
  int miscompares = 0;

  axi_reset_ctrl #(
    .NUM_REQ(4), .HOLD_W(8), .MIN_HOLD(TB_MIN_HOLD), .QUIESCE_TIMEOUT(TB_TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .hold_cycles (hold_cycles),
    .axi_idle    (axi_idle),
    .grant       (grant),
    .done        (done),
    .axi_reset   (axi_reset),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Power-on sequence; called on the negedge where reset_n has just risen (cycle 0).
  task automatic check_por(input string tag);
    for (int c = 1; c <= TB_MIN_HOLD + SETTLE_CYCLES; c++) begin
      @(negedge clk);
      chk({tag, "/axi_reset"}, 32'(axi_reset), 32'(c < TB_MIN_HOLD));
      chk({tag, "/busy"}, 32'(busy), 32'(c < TB_MIN_HOLD + SETTLE_CYCLES));
      chk({tag, "/grant"}, 32'(grant), 32'h0);
      chk({tag, "/done"}, 32'(done), 32'h0);
    end
  endtask

  // One sequence; called on the negedge of cycle 0 (IDLE, req already applied). Ends on the done cycle.
  task automatic check_seq(input string tag, input logic [3:0] g, input int h, input int k, input bit tmo);
    int last;
    last = 2 + k + h + SETTLE_CYCLES;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk({tag, "/grant"}, 32'(grant), 32'(g));
      chk({tag, "/busy"}, 32'(busy), 32'h1);
      chk({tag, "/axi_reset"}, 32'(axi_reset), 32'(c >= 2 + k && c < 2 + k + h));
      chk({tag, "/done"}, 32'(done), (c == last) ? 32'(g) : 32'h0);
      chk({tag, "/timeout_err"}, 32'(timeout_err), 32'(tmo && c == 1 + k));
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "/grant"}, 32'(grant), 32'h0);
    chk({tag, "/busy"}, 32'(busy), 32'h0);
    chk({tag, "/axi_reset"}, 32'(axi_reset), 32'h0);
    chk({tag, "/done"}, 32'(done), 32'h0);
  endtask

  initial begin
    reset_n     = 1'b0;
    req         = 4'b0000;
    hold_cycles = 8'd0;
    axi_idle    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst/axi_reset", 32'(axi_reset), 32'h1);
    chk("rst/busy", 32'(busy), 32'h1);
    chk("rst/grant", 32'(grant), 32'h0);
    chk("rst/done", 32'(done), 32'h0);
    chk("rst/timeout_err", 32'(timeout_err), 32'h0);

    reset_n = 1'b1;
    check_por("por");
    idle_check("por_idle");

    // Both requesters at once: bit 0 first, then bit 3 after one idle cycle.
    req         = 4'b1001;
    hold_cycles = 8'd16;
    check_seq("arb0", 4'b0001, 16, 0, 1'b0);
    idle_check("arb_gap");
    check_seq("arb3", 4'b1000, 16, 0, 1'b0);
    req = 4'b0000;
    idle_check("arb_end");

    req         = 4'b0010;
    hold_cycles = 8'd20;
    check_seq("single", 4'b0010, 20, 0, 1'b0);
    req = 4'b0000;
    idle_check("single_end");

    req         = 4'b0100;
    hold_cycles = 8'd3;
    check_seq("floor", 4'b0100, TB_MIN_HOLD, 0, 1'b0);
    req = 4'b0000;
    idle_check("floor_end");

    req         = 4'b0001;
    hold_cycles = 8'd0;
    axi_idle    = 1'b0;
    check_seq("tmo", 4'b0001, TB_MIN_HOLD, TB_TMO, 1'b1);
    req      = 4'b0000;
    axi_idle = 1'b1;
    idle_check("tmo_end");

    // Reset during ASSERT: requester 2 keeps req high and must be served after POR.
    req         = 4'b0100;
    hold_cycles = 8'd30;
    repeat (5) @(negedge clk);
    chk("mid/axi_reset_pre", 32'(axi_reset), 32'h1);
    chk("mid/grant_pre", 32'(grant), 32'h4);
    reset_n = 1'b0;
    #1;
    chk("mid/axi_reset", 32'(axi_reset), 32'h1);
    chk("mid/busy", 32'(busy), 32'h1);
    chk("mid/grant", 32'(grant), 32'h0);
    chk("mid/done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid/done_held", 32'(done), 32'h0);
    end
    reset_n = 1'b1;
    check_por("por2");
    check_seq("regrant", 4'b0100, 30, 0, 1'b0);
    req = 4'b0000;
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
